// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: access size encodings, FSM states and
// alignment classification helpers.
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 32;
    localparam int unsigned LSU_DATA_W = 32;

    localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD = 2'b10;
    localparam logic [1:0] LSU_SIZE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        GAP  = 3'd2,
        RD1  = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    // Access not naturally aligned for its size.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == LSU_SIZE_HALF) && off[0]) ||
               ((size == LSU_SIZE_WORD) && (off != 2'b00));
    endfunction

    // Access spills into the next word.
    function automatic logic lsu_crosses(input logic [1:0] size, input logic [1:0] off);
        return ((size == LSU_SIZE_HALF) && (off == 2'b11)) ||
               ((size == LSU_SIZE_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_ctrl_if.sv
// Core request, load-unit and writeback signals of load_ctrl.
interface load_ctrl_if #(
    parameter int unsigned TAG_W = 5
);
    import lsu_pkg::*;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [LSU_ADDR_W-1:0] req_addr_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [TAG_W-1:0]      req_tag_i;

    logic                  lu_read_o;
    logic [LSU_ADDR_W-1:0] lu_addr_o;
    logic                  lu_valid_i;
    logic [LSU_DATA_W-1:0] lu_data_i;

    logic                  wb_valid_o;
    logic                  wb_ready_i;
    logic [LSU_DATA_W-1:0] wb_data_o;
    logic [TAG_W-1:0]      wb_tag_o;
    logic                  wb_err_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_size_i, req_unsigned_i, req_tag_i,
        input  lu_valid_i, lu_data_i, wb_ready_i,
        output req_ready_o, lu_read_o, lu_addr_o,
        output wb_valid_o, wb_data_o, wb_tag_o, wb_err_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_size_i, req_unsigned_i, req_tag_i,
        output lu_valid_i, lu_data_i, wb_ready_i,
        input  req_ready_o, lu_read_o, lu_addr_o,
        input  wb_valid_o, wb_data_o, wb_tag_o, wb_err_o
    );

endinterface

// File: rtl/load_align.sv
// Combinational load result extraction: byte-shift the {hi,lo} word pair and
// sign/zero-extend to 32 bits.
module load_align
    import lsu_pkg::*;
(
    input  logic [LSU_DATA_W-1:0] i_lo,
    input  logic [LSU_DATA_W-1:0] i_hi,
    input  logic [1:0]            i_off,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    output logic [LSU_DATA_W-1:0] o_data
);

    logic [LSU_DATA_W-1:0] w_win;

    assign w_win = 32'({i_hi, i_lo} >> {i_off, 3'b000});

    always_comb begin
        o_data = '0;
        case (i_size)
            LSU_SIZE_BYTE: o_data = i_unsigned ? {24'd0, w_win[7:0]}
                                               : {{24{w_win[7]}}, w_win[7:0]};
            LSU_SIZE_HALF: o_data = i_unsigned ? {16'd0, w_win[15:0]}
                                               : {{16{w_win[15]}}, w_win[15:0]};
            LSU_SIZE_WORD: o_data = w_win;
            default:       o_data = '0;
        endcase
    end

endmodule

// File: rtl/load_ctrl.sv
// Single-outstanding load controller with alignment/extension and writeback.
// Define LOAD_MISALIGN_EN to serve misaligned loads (two reads when crossing a word).
module load_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic       clk,
    input  logic       rst_i,
    load_ctrl_if.slave bus
);

    lsu_state_e r_state, w_next;

    logic [1:0]            r_off;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_cross;
    logic [TAG_W-1:0]      r_tag;
    logic [LSU_DATA_W-1:0] r_lo;
    logic                  r_lu_read;
    logic [LSU_ADDR_W-1:0] r_lu_addr;
    logic                  r_wb_valid;
    logic [LSU_DATA_W-1:0] r_wb_data;
    logic [TAG_W-1:0]      r_wb_tag;
    logic                  r_wb_err;

    logic                  w_hs;
    logic                  w_bad;
    logic                  w_cross;
    logic [LSU_DATA_W-1:0] w_lo;
    logic [LSU_DATA_W-1:0] w_hi;
    logic [LSU_DATA_W-1:0] w_ext;

    assign w_hs = bus.req_valid_i && (r_state == IDLE);

`ifdef LOAD_MISALIGN_EN
    assign w_bad   = (bus.req_size_i == LSU_SIZE_RSVD);
    assign w_cross = lsu_crosses(bus.req_size_i, bus.req_addr_i[1:0]);
`else
    assign w_bad   = (bus.req_size_i == LSU_SIZE_RSVD) ||
                     lsu_misaligned(bus.req_size_i, bus.req_addr_i[1:0]);
    assign w_cross = 1'b0;
`endif

    // In RD1 the live bus word is the upper half of the pair.
    assign w_lo = (r_state == RD1) ? r_lo : bus.lu_data_i;
    assign w_hi = (r_state == RD1) ? bus.lu_data_i : '0;

    load_align u_align (
        .i_lo       (w_lo),
        .i_hi       (w_hi),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid_i) w_next = w_bad ? RESP : RD0;
            RD0:     if (bus.lu_valid_i)  w_next = r_cross ? GAP : RESP;
            GAP:     w_next = RD1;
            RD1:     if (bus.lu_valid_i)  w_next = RESP;
            RESP:    if (bus.wb_ready_i)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request capture, bus address and registered writeback payload.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_off      <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_cross    <= 1'b0;
            r_tag      <= '0;
            r_lo       <= '0;
            r_lu_read  <= 1'b0;
            r_lu_addr  <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_tag   <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            r_lu_read <= (w_next == RD0) || (w_next == RD1);
            if (w_hs) begin
                r_off      <= bus.req_addr_i[1:0];
                r_size     <= bus.req_size_i;
                r_unsigned <= bus.req_unsigned_i;
                r_cross    <= w_cross;
                r_tag      <= bus.req_tag_i;
                r_lu_addr  <= {bus.req_addr_i[LSU_ADDR_W-1:2], 2'b00};
            end
            if ((r_state == RD0) && bus.lu_valid_i) r_lo <= bus.lu_data_i;
            if (r_state == GAP) r_lu_addr <= r_lu_addr + 32'd4;
            if ((w_next == RESP) && (r_state != RESP)) begin
                r_wb_valid <= 1'b1;
                r_wb_err   <= (r_state == IDLE);
                r_wb_tag   <= (r_state == IDLE) ? bus.req_tag_i : r_tag;
                r_wb_data  <= (r_state == IDLE) ? '0 : w_ext;
            end else if ((r_state == RESP) && bus.wb_ready_i) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o = (r_state == IDLE);
    assign bus.lu_read_o   = r_lu_read;
    assign bus.lu_addr_o   = r_lu_addr;
    assign bus.wb_valid_o  = r_wb_valid;
    assign bus.wb_data_o   = r_wb_data;
    assign bus.wb_tag_o    = r_wb_tag;
    assign bus.wb_err_o    = r_wb_err;

endmodule

// File: tb/tb_load_ctrl.sv
// Directed table-driven bench for load_ctrl; expectations follow LOAD_MISALIGN_EN.
module tb_load_ctrl;
    import lsu_pkg::*;

    localparam int unsigned TAG_W = 5;

    logic clk;
    logic rst_i;
    int   n_checks;
    int   n_errors;

    load_ctrl_if #(.TAG_W(TAG_W)) bus ();

    load_ctrl #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  tag;
        logic [31:0] lo;
        logic [31:0] hi;
        int          nreads;
        int          hold;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [4:0] tag,
                                input logic [31:0] lo, input logic [31:0] hi,
                                input int nreads, input int hold,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] exp_data, input logic exp_err);
        vec_t v;
        v.addr = addr; v.size = size; v.uns = uns; v.tag = tag;
        v.lo = lo; v.hi = hi; v.nreads = nreads; v.hold = hold;
        v.a0 = a0; v.a1 = a1; v.exp_data = exp_data; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic vec_t mk_err(input logic [31:0] addr, input logic [1:0] size,
                                    input logic [4:0] tag);
        return mk(addr, size, 1'b0, tag, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 1'b1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = v.addr;
        bus.req_size_i     = v.size;
        bus.req_unsigned_i = v.uns;
        bus.req_tag_i      = v.tag;
        check({p, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = 32'hA5A5_A5A5;
        bus.req_tag_i   = 5'h00;
        if (v.nreads == 0) begin
            check({p, "_no_read"}, 32'(bus.lu_read_o), 32'd0);
        end else begin
            check({p, "_rd0"}, 32'(bus.lu_read_o), 32'd1);
            check({p, "_rd0_addr"}, bus.lu_addr_o, v.a0);
            @(negedge clk);
            check({p, "_rd0_hold"}, 32'(bus.lu_read_o), 32'd1);
            check({p, "_rd0_addr_hold"}, bus.lu_addr_o, v.a0);
            bus.lu_valid_i = 1'b1;
            bus.lu_data_i  = v.lo;
            @(negedge clk);
            bus.lu_valid_i = 1'b0;
            bus.lu_data_i  = 32'hDEAD_0000;
            check({p, "_rd0_drop"}, 32'(bus.lu_read_o), 32'd0);
            if (v.nreads == 2) begin
                check({p, "_gap_no_wb"}, 32'(bus.wb_valid_o), 32'd0);
                @(negedge clk);
                check({p, "_rd1"}, 32'(bus.lu_read_o), 32'd1);
                check({p, "_rd1_addr"}, bus.lu_addr_o, v.a1);
                bus.lu_valid_i = 1'b1;
                bus.lu_data_i  = v.hi;
                @(negedge clk);
                bus.lu_valid_i = 1'b0;
                bus.lu_data_i  = 32'hDEAD_0000;
                check({p, "_rd1_drop"}, 32'(bus.lu_read_o), 32'd0);
            end
        end
        check({p, "_wb_valid"}, 32'(bus.wb_valid_o), 32'd1);
        check({p, "_wb_data"}, bus.wb_data_o, v.exp_data);
        check({p, "_wb_err"}, 32'(bus.wb_err_o), 32'(v.exp_err));
        check({p, "_wb_tag"}, 32'(bus.wb_tag_o), 32'(v.tag));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check({p, "_hold_valid"}, 32'(bus.wb_valid_o), 32'd1);
            check({p, "_hold_data"}, bus.wb_data_o, v.exp_data);
            check({p, "_hold_noread"}, 32'(bus.lu_read_o), 32'd0);
            check({p, "_hold_busy"}, 32'(bus.req_ready_o), 32'd0);
        end
        bus.wb_ready_i = 1'b1;
        @(negedge clk);
        bus.wb_ready_i = 1'b0;
        check({p, "_wb_clear"}, 32'(bus.wb_valid_o), 32'd0);
        check({p, "_idle_ready"}, 32'(bus.req_ready_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = mk(32'h0000_1003, LSU_SIZE_BYTE, 1'b0, 5'd1,  32'h80AA_BBCC, 32'h0, 1, 0,
                      32'h0000_1000, 32'h0, 32'hFFFF_FF80, 1'b0);
        vecs[1]  = mk(32'h0000_2002, LSU_SIZE_HALF, 1'b1, 5'd2,  32'hBEEF_1234, 32'h0, 1, 3,
                      32'h0000_2000, 32'h0, 32'h0000_BEEF, 1'b0);
        vecs[2]  = mk(32'h0000_4000, LSU_SIZE_WORD, 1'b0, 5'd3,  32'hDEAD_BEEF, 32'h0, 1, 1,
                      32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 1'b0);
        vecs[3]  = mk(32'h0000_1001, LSU_SIZE_BYTE, 1'b1, 5'd4,  32'h1234_5678, 32'h0, 1, 0,
                      32'h0000_1000, 32'h0, 32'h0000_0056, 1'b0);
        vecs[4]  = mk(32'h0000_2000, LSU_SIZE_HALF, 1'b0, 5'd5,  32'h1234_F00D, 32'h0, 1, 0,
                      32'h0000_2000, 32'h0, 32'hFFFF_F00D, 1'b0);
        vecs[5]  = mk(32'h0000_2002, LSU_SIZE_HALF, 1'b0, 5'd6,  32'h7FFF_0000, 32'h0, 1, 0,
                      32'h0000_2000, 32'h0, 32'h0000_7FFF, 1'b0);
        vecs[6]  = mk_err(32'h0000_5000, LSU_SIZE_RSVD, 5'd7);
        vecs[7]  = mk(32'h0000_1002, LSU_SIZE_BYTE, 1'b0, 5'd8,  32'h00FF_7F00, 32'h0, 1, 0,
                      32'h0000_1000, 32'h0, 32'hFFFF_FFFF, 1'b0);
`ifdef LOAD_MISALIGN_EN
        vecs[8]  = mk(32'h0000_3001, LSU_SIZE_WORD, 1'b0, 5'd9,  32'h4433_2211, 32'h8877_6655, 2, 0,
                      32'h0000_3000, 32'h0000_3004, 32'h5544_3322, 1'b0);
        vecs[9]  = mk(32'h0000_3003, LSU_SIZE_WORD, 1'b0, 5'd10, 32'h4433_2211, 32'h8877_6655, 2, 0,
                      32'h0000_3000, 32'h0000_3004, 32'h7766_5544, 1'b0);
        vecs[10] = mk(32'h0000_2001, LSU_SIZE_HALF, 1'b0, 5'd11, 32'hAABB_CCDD, 32'h0, 1, 0,
                      32'h0000_2000, 32'h0, 32'hFFFF_BBCC, 1'b0);
        vecs[11] = mk(32'hFFFF_FFFF, LSU_SIZE_HALF, 1'b0, 5'd12, 32'h1122_3344, 32'h5566_77EE, 2, 1,
                      32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_EE11, 1'b0);
`else
        vecs[8]  = mk_err(32'h0000_3001, LSU_SIZE_WORD, 5'd9);
        vecs[9]  = mk_err(32'h0000_3003, LSU_SIZE_WORD, 5'd10);
        vecs[10] = mk_err(32'h0000_2001, LSU_SIZE_HALF, 5'd11);
        vecs[11] = mk_err(32'hFFFF_FFFF, LSU_SIZE_HALF, 5'd12);
`endif
        vecs[12] = mk_err(32'h0000_5003, LSU_SIZE_RSVD, 5'd13);
        vecs[13] = mk(32'h0000_7002, LSU_SIZE_BYTE, 1'b1, 5'd31, 32'h0080_0000, 32'h0, 1, 0,
                      32'h0000_7000, 32'h0, 32'h0000_0080, 1'b0);

        rst_i              = 1'b1;
        bus.req_valid_i    = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_size_i     = '0;
        bus.req_unsigned_i = 1'b0;
        bus.req_tag_i      = '0;
        bus.lu_valid_i     = 1'b0;
        bus.lu_data_i      = '0;
        bus.wb_ready_i     = 1'b0;

        #2;
        check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_lu_read", 32'(bus.lu_read_o), 32'd0);
        check("rst_lu_addr", bus.lu_addr_o, 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
        check("rst_wb_data", bus.wb_data_o, 32'd0);
        check("rst_wb_tag", 32'(bus.wb_tag_o), 32'd0);
        check("rst_wb_err", 32'(bus.wb_err_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        // Stray load-unit response while idle must be ignored.
        @(negedge clk);
        bus.lu_valid_i = 1'b1;
        bus.lu_data_i  = 32'h1357_9BDF;
        @(negedge clk);
        bus.lu_valid_i = 1'b0;
        check("idle_lu_valid_wb", 32'(bus.wb_valid_o), 32'd0);
        check("idle_lu_valid_ready", 32'(bus.req_ready_o), 32'd1);
        check("idle_lu_valid_read", 32'(bus.lu_read_o), 32'd0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset while a read is outstanding and never answered.
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = 32'h0000_6000;
        bus.req_size_i     = LSU_SIZE_WORD;
        bus.req_unsigned_i = 1'b0;
        bus.req_tag_i      = 5'd3;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("mid_rst_read_up", 32'(bus.lu_read_o), 32'd1);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("mid_rst_read_drop", 32'(bus.lu_read_o), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready_o), 32'd1);
        check("mid_rst_wb", 32'(bus.wb_valid_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_wb", 32'(bus.wb_valid_o), 32'd0);
            check("post_rst_no_read", 32'(bus.lu_read_o), 32'd0);
        end
        run_vec(vecs[0], 100);
        run_vec(vecs[6], 106);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_ctrl.md
LOAD_CTRL -- requirements
Module: load_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 5, width of the destination-register tag carried with each load.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_i  input  1  core presents a load request.
REQ-005 SHALL have port req_ready_o  output  1  block accepts the request this cycle.
REQ-006 SHALL have port req_addr_i  input  32  byte address.
REQ-007 SHALL have port req_size_i  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned_i  input  1  1 selects zero-extend, 0 selects sign-extend.
REQ-009 SHALL have port req_tag_i  input  TAG_W  tag returned with the result.
REQ-010 SHALL have port lu_read_o  output  1  read request to the downstream load unit, held until lu_valid_i.
REQ-011 SHALL have port lu_addr_o  output  32  word-aligned address (bits [1:0] = 00).
REQ-012 SHALL have port lu_valid_i  input  1  load unit returns data this cycle.
REQ-013 SHALL have port lu_data_i  input  32  returned word, valid only with lu_valid_i.
REQ-014 SHALL have port wb_valid_o  output  1  writeback result valid.
REQ-015 SHALL have port wb_ready_i  input  1  consumer takes the result.
REQ-016 SHALL have ports wb_data_o (output, 32), wb_tag_o (output, TAG_W) and wb_err_o (output, 1): extended data, tag, and misalignment/reserved-size error.

Function
REQ-017 SHALL implement FSM states IDLE, RD0, GAP, RD1 and RESP; only one load is in flight.
REQ-018 SHALL drive req_ready_o = 1 combinationally only in IDLE; a handshake is req_valid_i && req_ready_o.
REQ-019 On handshake in cycle N, SHALL register addr, size, unsigned and tag, and enter RD0 with lu_read_o = 1 in cycle N+1.
REQ-020 SHALL keep lu_read_o and lu_addr_o stable in RD/RD1 until the cycle lu_valid_i = 1, capture lu_data_i in that cycle, and drive lu_read_o = 0 in the following cycle.
REQ-021 SHALL ignore lu_valid_i outside RD0/RD1.
REQ-022 SHALL, for a single-word access with lu_valid_i in cycle M, enter RESP with wb_valid_o = 1 in cycle M+1.
REQ-023 SHALL extract the result as the 64-bit value {hi_word, lo_word} shifted right by 8*addr[1:0] and truncated to size; hi_word = 0 for single-word accesses.
REQ-024 SHALL sign-extend byte and half results from bit 7 or bit 15 when req_unsigned_i = 0, and zero-extend them otherwise; word results pass unchanged.
REQ-025 SHALL hold wb_valid_o, wb_data_o, wb_tag_o and wb_err_o stable in RESP until wb_ready_i = 1, then return to IDLE the next cycle.
REQ-026 SHALL treat req_size_i = 11 as an error: no bus access, RESP in cycle N+1, wb_err_o = 1, wb_data_o = 0.
REQ-027 SHALL never issue lu_read_o during IDLE, GAP or RESP.

Reset
REQ-028 SHALL, while rst_i = 1, force state IDLE and all outputs 0 (req_ready_o follows IDLE, so it reads 1).
REQ-029 SHALL, when rst_i asserts mid-transfer, drop lu_read_o asynchronously and discard the pending request with no writeback.

Configuration
REQ-030 SHALL, with LOAD_MISALIGN_EN undefined, treat any misaligned access (half with addr[0] = 1; word with addr[1:0] != 00) as an error: no bus access, RESP in cycle N+1, wb_err_o = 1, wb_data_o = 0.
REQ-031 SHALL, with LOAD_MISALIGN_EN defined, serve misaligned accesses inside one word with a single read, and serve accesses crossing a word boundary (half at addr[1:0] = 11; word at addr[1:0] != 00) as follows: read addr&~3 in RD0, lu_read_o = 0 for one cycle in GAP, read (addr&~3)+4 in RD1, then RESP; wb_err_o is then asserted only for size 11.
REQ-032 SHALL wrap the second address modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).

Structure
REQ-033 SHALL place the size encodings (LSU_SIZE_BYTE/HALF/WORD) and the FSM state typedef in shared package lsu_pkg.
REQ-034 SHALL put the extraction and extension datapath (REQ-023/024) in a purely combinational sub-module load_align.

Verification
REQ-035 SHALL cover: byte, signed, addr 0x1003, lu_data_i 0x80AABBCC -> one read at 0x1000, wb_data_o 0xFFFFFF80.
REQ-036 SHALL cover: half, unsigned, addr 0x2002, lu_data_i 0xBEEF1234 -> wb_data_o 0x0000BEEF; wb_valid_o held 3 cycles while wb_ready_i = 0, then IDLE.
REQ-037 SHALL cover: word, addr 0x3001, macro undefined -> no lu_read_o, wb_err_o = 1 in cycle N+1.
REQ-038 SHALL cover: word, addr 0x3003, macro defined, words 0x44332211 and 0x88776655 -> reads 0x3000 then 0x3004 separated by one idle cycle, wb_data_o 0x77665544.
REQ-039 SHALL cover: rst_i pulsed while lu_read_o = 1 and lu_valid_i never asserted -> lu_read_o = 0 immediately, no wb_valid_o, next request served normally.
